// File: rtl/poly_fan_tri_pkg.sv
// Shared geometry types for the clipper -> fan triangulator -> triangle setup path.
// MAX_VERTS and COORD_W here must match the parameters used on poly_fan_tri.
package poly_fan_tri_pkg;

  localparam int MAX_VERTS = 7;
  localparam int COORD_W   = 16;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } Vertex2D;

  typedef struct packed {
    logic [3:0]                num_verts;
    Vertex2D [MAX_VERTS-1:0]   verts;
  } Polygon2D;

  typedef struct packed {
    Vertex2D [2:0] v;
  } Triangle2D;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } fan_state_t;

  // A fan needs at least one triangle and must fit the vertex array.
  function automatic logic poly_ok(input logic [3:0] n);
    return (n >= 4'd3) && (n <= 4'(MAX_VERTS));
  endfunction

endpackage

// File: rtl/poly_fan_tri_if.sv
// Polygon-in / triangle-out handshake bundle for poly_fan_tri.
// master = the side feeding polygons and consuming triangles; slave = the fan block.
interface poly_fan_tri_if;
  import poly_fan_tri_pkg::*;

  logic      in_valid;
  logic      in_ready;
  Polygon2D  in_poly;
  logic      out_valid;
  logic      out_ready;
  Triangle2D out_tri;
  logic      out_last;

  modport master (
    output in_valid, in_poly, out_ready,
    input  in_ready, out_valid, out_tri, out_last
  );

  modport slave (
    input  in_valid, in_poly, out_ready,
    output in_ready, out_valid, out_tri, out_last
  );

endinterface

// File: rtl/poly_fan_tri_tri_area2.sv
// Doubled signed area of a 2D triangle, fully combinational and full precision.
// Reusable for back-face culling in triangle setup.
module tri_area2 #(
  parameter int COORD_W = 16
) (
  input  logic signed [COORD_W-1:0]   i_x0,
  input  logic signed [COORD_W-1:0]   i_y0,
  input  logic signed [COORD_W-1:0]   i_x1,
  input  logic signed [COORD_W-1:0]   i_y1,
  input  logic signed [COORD_W-1:0]   i_x2,
  input  logic signed [COORD_W-1:0]   i_y2,
  output logic signed [2*COORD_W+2:0] o_area2
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;
  localparam int AW = 2 * COORD_W + 3;

  logic signed [DW-1:0] w_dx1, w_dy1, w_dx2, w_dy2;
  logic signed [PW-1:0] w_p0, w_p1;

  // Every operand is sign-extended before the operation, so nothing wraps.
  assign w_dx1 = {i_x1[COORD_W-1], i_x1} - {i_x0[COORD_W-1], i_x0};
  assign w_dy1 = {i_y1[COORD_W-1], i_y1} - {i_y0[COORD_W-1], i_y0};
  assign w_dx2 = {i_x2[COORD_W-1], i_x2} - {i_x0[COORD_W-1], i_x0};
  assign w_dy2 = {i_y2[COORD_W-1], i_y2} - {i_y0[COORD_W-1], i_y0};

  assign w_p0 = PW'(w_dx1) * PW'(w_dy2);
  assign w_p1 = PW'(w_dx2) * PW'(w_dy1);

  assign o_area2 = AW'(w_p0) - AW'(w_p1);

endmodule

// File: rtl/poly_fan_tri.sv
// Accepts one convex polygon and emits it as a triangle fan (v0, vi, vi+1),
// dropping malformed polygons and optionally skipping zero-area non-final triangles.
module poly_fan_tri #(
  parameter int MAX_VERTS = 7,
  parameter int COORD_W   = 16,
  parameter bit CULL_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  poly_fan_tri_if.slave      bus,
  output logic [15:0]        drop_cnt
);
  import poly_fan_tri_pkg::*;

  localparam int IDX_W = $clog2(MAX_VERTS);

  fan_state_t                 r_state, w_state_n;
  logic [IDX_W-1:0]           r_idx, w_idx_n, w_idx_p1;
  Polygon2D                   r_poly;
  logic [15:0]                r_drop_cnt;
  logic                       w_capture, w_drop, w_last, w_cull, w_out_valid;
  logic signed [2*COORD_W+2:0] w_area2;
  Vertex2D                    w_v0, w_v1, w_v2;

  assign w_idx_p1 = r_idx + IDX_W'(1);
  assign w_v0     = r_poly.verts[0];
  assign w_v1     = r_poly.verts[r_idx];
  assign w_v2     = r_poly.verts[w_idx_p1];

  tri_area2 #(.COORD_W(COORD_W)) u_area (
    .i_x0    (w_v0.x), .i_y0 (w_v0.y),
    .i_x1    (w_v1.x), .i_y1 (w_v1.y),
    .i_x2    (w_v2.x), .i_y2 (w_v2.y),
    .o_area2 (w_area2)
  );

  // The final triangle is never culled so out_last always reaches downstream.
  assign w_last      = (4'(r_idx) == (r_poly.num_verts - 4'd2));
  assign w_cull      = CULL_ZERO && (w_area2 == '0) && !w_last;
  assign w_out_valid = (r_state == S_EMIT) && !w_cull;

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = w_out_valid;
  assign bus.out_tri   = {w_v2, w_v1, w_v0};
  assign bus.out_last  = w_last && w_out_valid;
  assign drop_cnt      = r_drop_cnt;

  // NOTE: every output of this block gets a default first; otherwise paths
  // that do not assign it would infer latches.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_capture = 1'b0;
    w_drop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          w_capture = 1'b1;
          if (!poly_ok(bus.in_poly.num_verts)) begin
            w_drop = 1'b1;
          end else begin
            w_state_n = S_EMIT;
            w_idx_n   = IDX_W'(1);
          end
        end
      end
      S_EMIT: begin
        if ((w_out_valid && bus.out_ready) || w_cull) begin
          if (w_last) w_state_n = S_IDLE;
          else        w_idx_n   = w_idx_p1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order. The polygon register is
  // reset too, because out_tri is defined as zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= IDX_W'(1);
      r_poly     <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      if (w_capture) r_poly <= bus.in_poly;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule
